// File: rtl/wm8731_i2s_adc_receiver_if.sv
// Signal bundle between the WM8731 ADC receiver and the board top / codec pins.
// The receiver is the master: it drives the codec clocks and the sample bus.
interface wm8731_i2s_adc_receiver_if #(
  parameter int w_sample = 16
);
  logic                en;
  logic                aud_xck;
  logic                aud_bclk;
  logic                aud_adclrck;
  logic                aud_adcdat;
  logic [w_sample-1:0] left;
  logic [w_sample-1:0] right;
  logic                valid;
  logic                busy;

  modport master (
    input  en, aud_adcdat,
    output aud_xck, aud_bclk, aud_adclrck, left, right, valid, busy
  );

  modport slave (
    output en, aud_adcdat,
    input  aud_xck, aud_bclk, aud_adclrck, left, right, valid, busy
  );
endinterface

// File: rtl/wm8731_i2s_adc_receiver.sv
// I2S master receiver for the WM8731 ADC path.
// Generates the codec master clock, bit clock and word select, and deserialises
// the serial ADC stream into left/right samples that are published together with
// a one-cycle valid strobe once per 64-bclk frame.
module wm8731_i2s_adc_receiver #(
  parameter int clk_mhz  = 50,
  parameter int mclk_div = 4,
  parameter int bclk_div = 16,
  parameter int w_sample = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  wm8731_i2s_adc_receiver_if.master aud
);

  localparam int mw = $clog2(mclk_div);
  localparam int cw = $clog2(bclk_div);

  localparam logic [mw-1:0] mclk_last = mw'(mclk_div - 1);
  localparam logic [mw-1:0] mclk_half = mw'(mclk_div / 2);
  localparam logic [cw-1:0] clk_last  = cw'(bclk_div - 1);
  localparam logic [cw-1:0] clk_half  = cw'(bclk_div / 2);
  localparam logic [4:0]    slot_last = 5'(w_sample);

  if (mclk_div < 2 || (mclk_div % 2) != 0 || bclk_div < 8 || (bclk_div % 2) != 0 ||
      w_sample < 1 || w_sample > 31 || clk_mhz < 1) begin : g_param_check
    $error("wm8731_i2s_adc_receiver: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_nxt;
  logic                active;
  logic [mw-1:0]       mclk_cnt, mclk_nxt;
  logic                xck_q;
  logic [cw-1:0]       clk_cnt, clk_cnt_nxt;
  logic                bclk_q, bclk_nxt;
  logic                lrclk_q;
  logic [5:0]          bit_cnt, bit_nxt;
  logic                sync1, sync2;
  logic [w_sample-1:0] shreg, shreg_nxt;
  logic [w_sample-1:0] left_hold, left_q, right_q;
  logic                valid_q;
  logic                fall_evt, frame_end, data_slot, last_slot;
  logic [4:0]          slot;

  // Frame-level control state; reset forces IDLE immediately, even mid-frame.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stopping is deferred to the frame end so lrclk never produces a short word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (aud.en) state_nxt = RUN;
      RUN:     if (!aud.en) state_nxt = DRAIN;
      DRAIN: begin
        if (aud.en)         state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clocks run only outside IDLE; busy mirrors that.
  always_comb begin
    active   = (state != IDLE);
    aud.busy = active;
  end

  // Counter arithmetic and bit-slot decode; a bclk falling event is also the sample point.
  always_comb begin
    mclk_nxt    = (mclk_cnt == mclk_last) ? '0 : mclk_cnt + 1'b1;
    clk_cnt_nxt = (clk_cnt == clk_last) ? '0 : clk_cnt + 1'b1;
    bclk_nxt    = (clk_cnt_nxt >= clk_half);
    bit_nxt     = bit_cnt + 6'd1;
    slot        = bit_cnt[4:0];
    fall_evt    = active && (clk_cnt == clk_last);
    frame_end   = fall_evt && (bit_cnt == 6'd63);
    data_slot   = (slot != 5'd0) && (slot <= slot_last);
    last_slot   = (slot == slot_last);
    shreg_nxt    = shreg << 1;
    shreg_nxt[0] = sync2;
  end

  // Free-running codec master clock, high for the second half of each period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mclk_cnt <= '0;
      xck_q    <= 1'b0;
    end else begin
      mclk_cnt <= mclk_nxt;
      xck_q    <= (mclk_nxt >= mclk_half);
    end
  end

  // Two-flop synchroniser for the codec data line, which is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= aud.aud_adcdat;
      sync2 <= sync1;
    end
  end

  // Bit clock, bit counter and word select; all park low while IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) begin
      clk_cnt <= '0;
      bclk_q  <= 1'b0;
      bit_cnt <= '0;
      lrclk_q <= 1'b0;
    end else begin
      clk_cnt <= clk_cnt_nxt;
      bclk_q  <= bclk_nxt;
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        lrclk_q <= bit_nxt[5];
      end
    end
  end

  // Shift in data slots; the left word waits in left_hold so both channels publish together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      left_hold <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (fall_evt && data_slot) begin
        shreg <= shreg_nxt;
        if (last_slot) begin
          if (!bit_cnt[5]) begin
            left_hold <= shreg_nxt;
          end else begin
            right_q <= shreg_nxt;
            left_q  <= left_hold;
            valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign aud.aud_xck     = xck_q;
  assign aud.aud_bclk    = bclk_q;
  assign aud.aud_adclrck = lrclk_q;
  assign aud.left        = left_q;
  assign aud.right       = right_q;
  assign aud.valid       = valid_q;

endmodule
